pam4_rx_gearbox: RTL and testbench

Receive-side symbol-to-word gearbox. It sits directly after the RX precoder and is the inverse of the TX word-to-symbol path.
- Consumes one 2-bit PAM4 symbol per enabled cycle.
- Optionally Gray-demaps each symbol.
- Packs symbols MSB-first into DATA_W-bit words for the FEC decoder.
- Output uses a valid/ready handshake behind a 2-entry FIFO.
- Provides a slip control for word alignment and a sticky overflow flag.

---
 rtl/pam4_pkg.sv | 25 ++
 rtl/pam4_rx_gearbox_if.sv | 11 +
 rtl/sync_fifo2.sv | 48 ++++
 rtl/pam4_rx_gearbox.sv | 68 ++++++
 tb/tb_pam4_rx_gearbox.sv | 189 ++++++++++++++++++
 5 files changed

// File: rtl/pam4_pkg.sv
// Shared PAM4 symbol types and Gray mapping helpers used by the RX gearbox and TX mapper.
package pam4_pkg;

  typedef logic [1:0] pam4_sym_t;

  typedef enum logic {
    MODE_BYPASS = 1'b0,
    MODE_GRAY   = 1'b1
  } demap_mode_t;

  localparam pam4_sym_t PAM4_L0 = 2'd0;
  localparam pam4_sym_t PAM4_L1 = 2'd1;
  localparam pam4_sym_t PAM4_L2 = 2'd2;
  localparam pam4_sym_t PAM4_L3 = 2'd3;

  // Level 0..3 maps to 00,01,11,10; the 2-bit Gray code is its own inverse.
  function automatic logic [1:0] gray_to_bits(input pam4_sym_t s);
    return {s[1], s[1] ^ s[0]};
  endfunction

  function automatic pam4_sym_t bits_to_gray(input logic [1:0] b);
    return {b[1], b[1] ^ b[0]};
  endfunction

endpackage

// File: rtl/pam4_rx_gearbox_if.sv
// Word-side valid/ready bus between the RX gearbox and the FEC decoder.
interface pam4_rx_gearbox_if #(parameter int DATA_W = 80);

  logic [DATA_W-1:0] word_out;
  logic              word_valid;
  logic              word_ready;

  modport master (output word_out, output word_valid, input word_ready);
  modport slave  (input word_out, input word_valid, output word_ready);

endinterface

// File: rtl/sync_fifo2.sv
// Two-entry synchronous FIFO; head reads as zero when empty, a push while full without a pop is dropped.
module sync_fifo2 #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] head
);

  logic [WIDTH-1:0] mem [2];
  logic             rd_ptr;
  logic             wr_ptr;
  logic [1:0]       count;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == 2'd0);
  assign full    = (count == 2'd2);
  assign do_pop  = pop && !empty;
  // When full, a simultaneous pop frees the slot the new word lands in.
  assign do_push = push && (!full || do_pop);
  assign head    = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (!rstn) begin
      mem[0] <= '0;
      mem[1] <= '0;
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= ~wr_ptr;
      end
      if (do_pop) begin
        rd_ptr <= ~rd_ptr;
      end
      count <= count + 2'(do_push) - 2'(do_pop);
    end
  end

endmodule

// File: rtl/pam4_rx_gearbox.sv
// RX symbol-to-word gearbox: optional Gray demap, MSB-first packing, 2-entry output FIFO.
module pam4_rx_gearbox
  import pam4_pkg::*;
#(
  parameter int DATA_W = 80
) (
  input  logic                         clk,
  input  logic                         rstn,
  input  pam4_sym_t                    symbol_in,
  input  logic                         en,
  input  logic                         gray_mode,
  input  logic                         slip,
  pam4_rx_gearbox_if.master            word_if,
  output logic                         overflow,
  output logic [$clog2(DATA_W/2)-1:0]  sym_count
);

  localparam int SYMS  = DATA_W / 2;
  localparam int CNT_W = $clog2(SYMS);

  demap_mode_t       mode;
  logic [DATA_W-1:0] shreg;
  logic [1:0]        bits;
  logic              accept;
  logic              last;
  logic [DATA_W-1:0] word_next;
  logic              fifo_full;
  logic              fifo_empty;
  logic              pop;

  assign bits      = (mode == MODE_GRAY) ? gray_to_bits(symbol_in) : symbol_in;
  assign accept    = en && !slip;
  assign last      = accept && (sym_count == CNT_W'(SYMS - 1));
  assign word_next = {shreg[DATA_W-3:0], bits};
  assign pop       = !fifo_empty && word_if.word_ready;

  assign word_if.word_valid = !fifo_empty;

  // The mode register only loads while reset is held, so gray_mode can be left floating afterwards.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      mode      <= gray_mode ? MODE_GRAY : MODE_BYPASS;
      shreg     <= '0;
      sym_count <= '0;
      overflow  <= 1'b0;
    end else begin
      if (accept) begin
        shreg     <= word_next;
        sym_count <= last ? '0 : sym_count + CNT_W'(1);
      end
      if (last && fifo_full && !pop) begin
        overflow <= 1'b1;
      end
    end
  end

  sync_fifo2 #(.WIDTH(DATA_W)) u_fifo (
    .clk       (clk),
    .rstn      (rstn),
    .push      (last),
    .push_data (word_next),
    .pop       (pop),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .head      (word_if.word_out)
  );

endmodule

// File: tb/tb_pam4_rx_gearbox.sv
// Directed self-checking bench for pam4_rx_gearbox at DATA_W = 8.
module tb_pam4_rx_gearbox;
  import pam4_pkg::*;

  localparam int DATA_W = 8;

  typedef struct {
    logic       rstn;
    logic       gray;
    logic       en;
    logic       slip;
    logic [1:0] sym;
    logic       ready;
    logic [7:0] exp_word;
    logic       exp_valid;
    logic [1:0] exp_cnt;
    logic       exp_ovf;
  } vec_t;

  logic       clk = 1'b0;
  logic       rstn;
  pam4_sym_t  symbol_in;
  logic       en;
  logic       gray_mode;
  logic       slip;
  logic       overflow;
  logic [1:0] sym_count;

  int checks = 0;
  int errors = 0;

  vec_t vecs[$];

  pam4_rx_gearbox_if #(.DATA_W(DATA_W)) bus ();

  pam4_rx_gearbox #(.DATA_W(DATA_W)) dut (
    .clk       (clk),
    .rstn      (rstn),
    .symbol_in (symbol_in),
    .en        (en),
    .gray_mode (gray_mode),
    .slip      (slip),
    .word_if   (bus),
    .overflow  (overflow),
    .sym_count (sym_count)
  );

  always #5 clk = ~clk;

  function automatic vec_t mk(input logic r, input logic g, input logic e, input logic s,
                              input logic [1:0] sy, input logic rdy, input logic [7:0] w,
                              input logic v, input logic [1:0] c, input logic o);
    vec_t t;
    t.rstn = r; t.gray = g; t.en = e; t.slip = s; t.sym = sy; t.ready = rdy;
    t.exp_word = w; t.exp_valid = v; t.exp_cnt = c; t.exp_ovf = o;
    return t;
  endfunction

  // Inputs change on the falling edge; outputs are sampled 1 time unit after the rising edge.
  task automatic applyStimulus(input logic r, input logic g, input logic e, input logic s,
                               input logic [1:0] sy, input logic rdy);
    @(negedge clk);
    rstn = r; gray_mode = g; en = e; slip = s; symbol_in = sy; bus.word_ready = rdy;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [7:0] w, input logic v,
                             input logic [1:0] c, input logic o);
    checks += 4;
    if (bus.word_out !== w) begin
      errors++;
      $display("[TB] FAIL %s word_out: got %h expected %h", name, bus.word_out, w);
    end
    if (bus.word_valid !== v) begin
      errors++;
      $display("[TB] FAIL %s word_valid: got %b expected %b", name, bus.word_valid, v);
    end
    if (sym_count !== c) begin
      errors++;
      $display("[TB] FAIL %s sym_count: got %0d expected %0d", name, sym_count, c);
    end
    if (overflow !== o) begin
      errors++;
      $display("[TB] FAIL %s overflow: got %b expected %b", name, overflow, o);
    end
  endtask

  task automatic symStep(input string name, input logic [1:0] sy, input logic rdy,
                         input logic [7:0] w, input logic v, input logic [1:0] c, input logic o);
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, sy, rdy);
    checkOutput(name, w, v, c, o);
  endtask

  task automatic idleStep(input string name, input logic rdy,
                          input logic [7:0] w, input logic v, input logic [1:0] c, input logic o);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 2'd0, rdy);
    checkOutput(name, w, v, c, o);
  endtask

  initial begin
    rstn = 1'b0; gray_mode = 1'b1; en = 1'b0; slip = 1'b0; symbol_in = 2'd0;
    bus.word_ready = 1'b1;

    // Gray mode 0,1,2,3 back-to-back: 8'h1E valid for exactly one cycle
    vecs.push_back(mk(0, 1, 0, 0, 0, 1, 8'h00, 0, 0, 0));
    vecs.push_back(mk(1, 0, 1, 0, 0, 1, 8'h00, 0, 1, 0));
    vecs.push_back(mk(1, 0, 1, 0, 1, 1, 8'h00, 0, 2, 0));
    vecs.push_back(mk(1, 0, 1, 0, 2, 1, 8'h00, 0, 3, 0));
    vecs.push_back(mk(1, 0, 1, 0, 3, 1, 8'h1E, 1, 0, 0));
    vecs.push_back(mk(1, 0, 0, 0, 0, 1, 8'h00, 0, 0, 0));
    vecs.push_back(mk(1, 0, 0, 0, 0, 1, 8'h00, 0, 0, 0));
    // Bypass 3,2,1,0 with gaps; gray_mode toggled outside reset must not matter
    vecs.push_back(mk(0, 0, 0, 0, 0, 1, 8'h00, 0, 0, 0));
    vecs.push_back(mk(1, 1, 1, 0, 3, 1, 8'h00, 0, 1, 0));
    vecs.push_back(mk(1, 1, 0, 0, 0, 1, 8'h00, 0, 1, 0));
    vecs.push_back(mk(1, 1, 1, 0, 2, 1, 8'h00, 0, 2, 0));
    vecs.push_back(mk(1, 0, 0, 1, 3, 1, 8'h00, 0, 2, 0));
    vecs.push_back(mk(1, 1, 1, 0, 1, 1, 8'h00, 0, 3, 0));
    vecs.push_back(mk(1, 0, 0, 0, 0, 1, 8'h00, 0, 3, 0));
    vecs.push_back(mk(1, 1, 1, 0, 0, 1, 8'hE4, 1, 0, 0));
    vecs.push_back(mk(1, 0, 0, 0, 0, 1, 8'h00, 0, 0, 0));
    // Gray with a slipped symbol first
    vecs.push_back(mk(0, 1, 0, 0, 0, 1, 8'h00, 0, 0, 0));
    vecs.push_back(mk(1, 0, 1, 1, 1, 1, 8'h00, 0, 0, 0));
    vecs.push_back(mk(1, 0, 1, 0, 0, 1, 8'h00, 0, 1, 0));
    vecs.push_back(mk(1, 0, 1, 0, 1, 1, 8'h00, 0, 2, 0));
    vecs.push_back(mk(1, 0, 1, 0, 2, 1, 8'h00, 0, 3, 0));
    vecs.push_back(mk(1, 0, 1, 0, 3, 1, 8'h1E, 1, 0, 0));
    vecs.push_back(mk(1, 0, 0, 0, 0, 1, 8'h00, 0, 0, 0));
    // Two symbols, reset pulse taking priority over en, then a clean Gray word
    vecs.push_back(mk(1, 0, 1, 0, 2, 1, 8'h00, 0, 1, 0));
    vecs.push_back(mk(1, 0, 1, 0, 3, 1, 8'h00, 0, 2, 0));
    vecs.push_back(mk(0, 1, 1, 0, 1, 1, 8'h00, 0, 0, 0));
    vecs.push_back(mk(1, 0, 1, 0, 0, 1, 8'h00, 0, 1, 0));
    vecs.push_back(mk(1, 0, 1, 0, 1, 1, 8'h00, 0, 2, 0));
    vecs.push_back(mk(1, 0, 1, 0, 2, 1, 8'h00, 0, 3, 0));
    vecs.push_back(mk(1, 0, 1, 0, 3, 1, 8'h1E, 1, 0, 0));
    vecs.push_back(mk(1, 0, 0, 0, 0, 1, 8'h00, 0, 0, 0));

    foreach (vecs[i]) begin
      applyStimulus(vecs[i].rstn, vecs[i].gray, vecs[i].en, vecs[i].slip, vecs[i].sym, vecs[i].ready);
      checkOutput($sformatf("vec%0d", i), vecs[i].exp_word, vecs[i].exp_valid,
                  vecs[i].exp_cnt, vecs[i].exp_ovf);
    end

    // Overflow: A=1E, B=E4, C=AA with ready low; C is dropped, A and B survive in order
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 1'b0);
    checkOutput("ovf_reset", 8'h00, 1'b0, 2'd0, 1'b0);
    symStep("ovf_a0", 2'd0, 1'b0, 8'h00, 1'b0, 2'd1, 1'b0);
    symStep("ovf_a1", 2'd1, 1'b0, 8'h00, 1'b0, 2'd2, 1'b0);
    symStep("ovf_a2", 2'd2, 1'b0, 8'h00, 1'b0, 2'd3, 1'b0);
    symStep("ovf_a3", 2'd3, 1'b0, 8'h1E, 1'b1, 2'd0, 1'b0);
    symStep("ovf_b0", 2'd2, 1'b0, 8'h1E, 1'b1, 2'd1, 1'b0);
    symStep("ovf_b1", 2'd3, 1'b0, 8'h1E, 1'b1, 2'd2, 1'b0);
    symStep("ovf_b2", 2'd1, 1'b0, 8'h1E, 1'b1, 2'd3, 1'b0);
    symStep("ovf_b3", 2'd0, 1'b0, 8'h1E, 1'b1, 2'd0, 1'b0);
    symStep("ovf_c0", 2'd3, 1'b0, 8'h1E, 1'b1, 2'd1, 1'b0);
    symStep("ovf_c1", 2'd3, 1'b0, 8'h1E, 1'b1, 2'd2, 1'b0);
    symStep("ovf_c2", 2'd3, 1'b0, 8'h1E, 1'b1, 2'd3, 1'b0);
    symStep("ovf_c3", 2'd3, 1'b0, 8'h1E, 1'b1, 2'd0, 1'b1);
    idleStep("ovf_hold", 1'b0, 8'h1E, 1'b1, 2'd0, 1'b1);
    idleStep("ovf_popa", 1'b1, 8'hE4, 1'b1, 2'd0, 1'b1);
    idleStep("ovf_popb", 1'b1, 8'h00, 1'b0, 2'd0, 1'b1);
    idleStep("ovf_noc", 1'b1, 8'h00, 1'b0, 2'd0, 1'b1);

    // Full FIFO with ready rising exactly as the third word completes: no loss
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 1'b0);
    checkOutput("full_reset", 8'h00, 1'b0, 2'd0, 1'b0);
    symStep("full_a0", 2'd0, 1'b0, 8'h00, 1'b0, 2'd1, 1'b0);
    symStep("full_a1", 2'd1, 1'b0, 8'h00, 1'b0, 2'd2, 1'b0);
    symStep("full_a2", 2'd2, 1'b0, 8'h00, 1'b0, 2'd3, 1'b0);
    symStep("full_a3", 2'd3, 1'b0, 8'h1E, 1'b1, 2'd0, 1'b0);
    symStep("full_b0", 2'd3, 1'b0, 8'h1E, 1'b1, 2'd1, 1'b0);
    symStep("full_b1", 2'd3, 1'b0, 8'h1E, 1'b1, 2'd2, 1'b0);
    symStep("full_b2", 2'd3, 1'b0, 8'h1E, 1'b1, 2'd3, 1'b0);
    symStep("full_b3", 2'd3, 1'b0, 8'h1E, 1'b1, 2'd0, 1'b0);
    symStep("full_c0", 2'd1, 1'b0, 8'h1E, 1'b1, 2'd1, 1'b0);
    symStep("full_c1", 2'd2, 1'b0, 8'h1E, 1'b1, 2'd2, 1'b0);
    symStep("full_c2", 2'd3, 1'b0, 8'h1E, 1'b1, 2'd3, 1'b0);
    symStep("full_c3", 2'd0, 1'b1, 8'hAA, 1'b1, 2'd0, 1'b0);
    idleStep("full_popb", 1'b1, 8'h78, 1'b1, 2'd0, 1'b0);
    idleStep("full_popc", 1'b1, 8'h00, 1'b0, 2'd0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
